// File: rtl/turtle_pkg.sv
// Shared constants and helpers for the RV32I decode stage feeding the integer ALU.
package turtle_pkg;

    localparam int XLEN    = 32;
    localparam int SRA_BIT = 10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SR   = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_OP,
        CLS_OP_IMM,
        CLS_LUI,
        CLS_AUIPC
    } op_class_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      ctrl;
        logic [4:0]      rd;
        logic            wb_en;
        logic            illegal;
    } dec_out_t;

    // The ALU reads the shift amount from B[4:0] and the arithmetic select from B[SRA_BIT].
    function automatic logic [XLEN-1:0] shift_operand(input logic sra, input logic [4:0] shamt);
        logic [XLEN-1:0] b;
        b          = '0;
        b[SRA_BIT] = sra;
        b[4:0]     = shamt;
        return b;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction-side, regfile, writeback and ALU-side signals of the decode stage.
interface decode_stage_if;
    import turtle_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [2:0]      out_ctrl;
    logic [4:0]      out_rd;
    logic            out_wb_en;
    logic            out_illegal;

    // Environment side: fetch, register file, writeback and ALU.
    modport master (
        output in_valid, in_instr, in_pc, rs1_data, rs2_data,
        output wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr,
        input  out_valid, out_a, out_b, out_ctrl, out_rd, out_wb_en, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, in_pc, rs1_data, rs2_data,
        input  wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, rs1_addr, rs2_addr,
        output out_valid, out_a, out_b, out_ctrl, out_rd, out_wb_en, out_illegal
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction (I/U types) and shift-operand formatting for the ALU B input.
module imm_gen
    import turtle_pkg::*;
(
    input  logic [31:12]     instr_hi,
    input  logic [4:0]       rs2_shamt,
    output logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  imm_u,
    output logic [XLEN-1:0]  shift_b_imm,
    output logic [XLEN-1:0]  shift_b_reg
);

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       sra;

    assign funct3 = instr_hi[14:12];
    assign funct7 = instr_hi[31:25];

    // Only a right shift can be arithmetic; SLL/SLLI never set the select bit.
    assign sra = (funct3 == ALU_SR) && (funct7 == F7_ALT);

    assign imm_i       = {{20{instr_hi[31]}}, instr_hi[31:20]};
    assign imm_u       = {instr_hi[31:12], 12'b0};
    assign shift_b_imm = shift_operand(sra, instr_hi[24:20]);
    assign shift_b_reg = shift_operand(sra, rs2_shamt);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage for ALU-class ops: regfile read, writeback forwarding, RAW stall
// against the held instruction, and one registered output stage with valid/ready.
module decode_stage
    import turtle_pkg::*;
(
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];

    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;

    logic [1:0][4:0]      rs_addr;
    logic [1:0][XLEN-1:0] rs_raw;
    logic [1:0][XLEN-1:0] rs_val;

    assign rs_addr[0] = rs1;
    assign rs_addr[1] = rs2;
    assign rs_raw[0]  = bus.rs1_data;
    assign rs_raw[1]  = bus.rs2_data;

    // Writeback of this cycle bypasses the regfile; x0 is hardwired to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign rs_val[gi] = (rs_addr[gi] == 5'd0) ? '0 :
                                (bus.wb_valid && (bus.wb_rd == rs_addr[gi])) ? bus.wb_data :
                                rs_raw[gi];
        end
    endgenerate

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shift_b_imm;
    logic [XLEN-1:0] shift_b_reg;

    imm_gen u_imm_gen (
        .instr_hi    (bus.in_instr[31:12]),
        .rs2_shamt   (rs_val[1][4:0]),
        .imm_i       (imm_i),
        .imm_u       (imm_u),
        .shift_b_imm (shift_b_imm),
        .shift_b_reg (shift_b_reg)
    );

    op_class_e cls;
    logic      legal;
    logic      is_shift;

    assign is_shift = (funct3 == ALU_SLL) || (funct3 == ALU_SR);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == ALU_SLL)
                    cls = (funct7 == F7_BASE) ? CLS_OP_IMM : CLS_ILLEGAL;
                else if (funct3 == ALU_SR)
                    cls = (funct7 == F7_BASE || funct7 == F7_ALT) ? CLS_OP_IMM : CLS_ILLEGAL;
                else
                    cls = CLS_OP_IMM;
            end
            OPC_OP: begin
                if (funct7 == F7_BASE)
                    cls = CLS_OP;
                else if (funct7 == F7_ALT && (funct3 == ALU_ADD || funct3 == ALU_SR))
                    cls = CLS_OP;
                else
                    cls = CLS_ILLEGAL;
            end
            OPC_LUI:   cls = CLS_LUI;
            OPC_AUIPC: cls = CLS_AUIPC;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    assign legal = (cls != CLS_ILLEGAL);

    dec_out_t dec;

    always_comb begin
        dec         = '0;
        dec.rd      = rd;
        dec.illegal = !legal;
        dec.wb_en   = legal && (rd != 5'd0);
        case (cls)
            CLS_OP_IMM: begin
                dec.a    = rs_val[0];
                dec.b    = is_shift ? shift_b_imm : imm_i;
                dec.ctrl = funct3;
            end
            CLS_OP: begin
                dec.a    = rs_val[0];
                dec.ctrl = funct3;
                if (funct3 == ALU_ADD && funct7 == F7_ALT)
                    dec.b = ~rs_val[1] + XLEN'(1);
                else if (is_shift)
                    dec.b = shift_b_reg;
                else
                    dec.b = rs_val[1];
            end
            CLS_LUI: begin
                dec.b = imm_u;
            end
            CLS_AUIPC: begin
                dec.a = bus.in_pc;
                dec.b = imm_u;
            end
            default: ;
        endcase
    end

    dec_out_t out_q;
    dec_out_t out_d;
    logic     out_valid_q;
    logic     out_valid_d;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     hazard;
    logic     accept;

    assign uses_rs1 = (cls == CLS_OP) || (cls == CLS_OP_IMM);
    assign uses_rs2 = (cls == CLS_OP);

    // The held instruction's result is not in the regfile yet; wait until it has left.
    assign hazard = bus.in_valid && out_valid_q && out_q.wb_en && (out_q.rd != 5'd0) &&
                    ((uses_rs1 && rs1 == out_q.rd) || (uses_rs2 && rs2 == out_q.rd));

    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = dec;
        end else if (bus.out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_q.a;
    assign bus.out_b       = out_q.b;
    assign bus.out_ctrl    = out_q.ctrl;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_wb_en   = out_q.wb_en;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard plus stall/reset sequences.
module tb_decode_stage;

    logic clk;
    logic reset;

    decode_stage_if dif ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rs1d, input logic [31:0] rs2d,
                                input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                                input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                                input logic [4:0] rd, input logic wb_en, input logic illegal);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.exp = '{instr, a, b, ctrl, rd, wb_en, illegal};
        return v;
    endfunction

    // Scoreboard: each negedge with out_valid && out_ready is one consumed result.
    always @(negedge clk) begin
        if (!reset && dif.out_valid && dif.out_ready) begin
            exp_t e;
            total++;
            txn++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL txn%0d unexpected output a=%h b=%h (scoreboard empty)", txn, dif.out_a, dif.out_b);
            end else begin
                e = sb.pop_front();
                if (dif.out_a != e.a || dif.out_b != e.b || dif.out_ctrl != e.ctrl ||
                    dif.out_wb_en != e.wb_en || dif.out_illegal != e.illegal ||
                    (!e.illegal && dif.out_rd != e.rd)) begin
                    bad++;
                    $display("FAIL txn%0d instr=%h got a=%h b=%h ctrl=%0d rd=%0d wb=%b ill=%b want a=%h b=%h ctrl=%0d rd=%0d wb=%b ill=%b",
                             txn, e.instr, dif.out_a, dif.out_b, dif.out_ctrl, dif.out_rd, dif.out_wb_en,
                             dif.out_illegal, e.a, e.b, e.ctrl, e.rd, e.wb_en, e.illegal);
                end else begin
                    $display("txn%0d instr=%h a=%h b=%h ctrl=%0d rd=%0d wb=%b ill=%b ok",
                             txn, e.instr, dif.out_a, dif.out_b, dif.out_ctrl, dif.out_rd,
                             dif.out_wb_en, dif.out_illegal);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        dif.in_valid = 1'b1;
        dif.in_instr = v.instr;
        dif.in_pc    = v.pc;
        dif.rs1_data = v.rs1d;
        dif.rs2_data = v.rs2d;
        dif.wb_valid = v.wbv;
        dif.wb_rd    = v.wbrd;
        dif.wb_data  = v.wbd;
    endtask

    // Present one instruction until accepted; waited reports the stall cycles.
    task automatic send(input vec_t v, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        drive(v);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                sb.push_back(v.exp);
                got = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout instr=%h in_ready=%b want=1", v.instr, dif.in_ready);
        end
        dif.in_valid = 1'b0;
        dif.wb_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        dif.out_ready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !dif.out_valid) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d out_valid=%b want 0/0", sb.size(), dif.out_valid);
        end
    endtask

    vec_t vecs[16];
    int   w;

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(32'h00500093, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 32'h5, 0, 1, 1, 0);
        vecs[1]  = mk(32'h402081B3, 0, 10, 3, 0, 0, 0, 32'd10, 32'hFFFFFFFD, 0, 3, 1, 0);
        vecs[2]  = mk(32'h407352B3, 0, 32'h80000000, 32'hFFFFFFE4, 0, 0, 0, 32'h80000000, 32'h404, 5, 5, 1, 0);
        vecs[3]  = mk(32'h007352B3, 0, 32'h80000000, 32'hFFFFFFE4, 0, 0, 0, 32'h80000000, 32'h4, 5, 5, 1, 0);
        vecs[4]  = mk(32'h12345237, 0, 32'h1111, 32'h2222, 0, 0, 0, 32'h0, 32'h12345000, 0, 4, 1, 0);
        vecs[5]  = mk(32'h00001317, 32'h100, 32'h1111, 32'h2222, 0, 0, 0, 32'h100, 32'h1000, 0, 6, 1, 0);
        vecs[6]  = mk(32'h00000073, 32'h200, 32'h1111, 32'h2222, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(32'hFFF1C113, 0, 32'h0F0F0F0F, 0, 0, 0, 0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4, 2, 1, 0);
        vecs[8]  = mk(32'h41F0D093, 0, 32'h80000000, 0, 0, 0, 0, 32'h80000000, 32'h41F, 5, 1, 1, 0);
        vecs[9]  = mk(32'h40109093, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[10] = mk(32'h4020F1B3, 0, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 0, 3, 0, 1);
        vecs[11] = mk(32'h00208033, 0, 5, 6, 0, 0, 0, 32'd5, 32'd6, 0, 0, 0, 0);
        vecs[12] = mk(32'h0020B1B3, 0, 1, 2, 0, 0, 0, 32'd1, 32'd2, 3, 3, 1, 0);
        vecs[13] = mk(32'h002081B3, 0, 32'h11, 32'h22, 1, 2, 32'h55, 32'h11, 32'h55, 0, 3, 1, 0);
        vecs[14] = mk(32'h00500093, 0, 32'h77, 0, 1, 0, 32'h99, 32'h0, 32'h5, 0, 1, 1, 0);
        vecs[15] = mk(32'h00331293, 0, 32'h1, 0, 0, 0, 0, 32'h1, 32'h3, 1, 5, 1, 0);

        reset         = 1'b1;
        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.in_pc     = '0;
        dif.rs1_data  = '0;
        dif.rs2_data  = '0;
        dif.wb_valid  = 1'b0;
        dif.wb_rd     = '0;
        dif.wb_data   = '0;
        dif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_out_valid", {31'b0, dif.out_valid}, 0);
        check("reset_fields", dif.out_a | dif.out_b |
              {24'b0, dif.out_ctrl, dif.out_rd} | {30'b0, dif.out_wb_en, dif.out_illegal}, 0);

        for (int i = 0; i < 16; i++) send(vecs[i], w);
        drain();

        // RAW stall: addi x1 held, add x2,x1,x1 must wait for it to drain, then forward x1 from wb.
        dif.out_ready = 1'b0;
        send(vecs[0], w);
        drive(mk(32'h00108133, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        check("hazard_in_ready", {31'b0, dif.in_ready}, 0);
        @(posedge clk);
        #1;
        send(mk(32'h00108133, 0, 0, 0, 1, 1, 32'h7, 32'h7, 32'h7, 0, 2, 1, 0), w);
        check("hazard_release_wait", w, 0);
        drain();

        // An illegal instruction naming x1 as rd must not stall a reader of x1.
        dif.out_ready = 1'b0;
        send(vecs[9], w);
        dif.out_ready = 1'b1;
        send(mk(32'h001081B3, 0, 32'h4, 32'h4, 0, 0, 0, 32'h4, 32'h4, 0, 3, 1, 0), w);
        check("illegal_no_stall", w, 0);
        drain();

        // Reset while an instruction is held and the next one is stalled behind it.
        dif.out_ready = 1'b0;
        send(vecs[0], w);
        drive(mk(32'h00108133, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("stall_before_reset", {31'b0, dif.in_ready}, 0);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        dif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_out_valid", {31'b0, dif.out_valid}, 0);
        check("midreset_out_b", dif.out_b, 0);
        sb.delete();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage directly upstream of the integer ALU: accepts one RV32I instruction per handshake, reads the register file and resolves forwarding.
- Produces registered ALU operands `A`/`B`/`ctrl` in the encoding the ALU consumes.
- Handles ALU-class ops only: OP, OP-IMM, LUI, AUIPC. Anything else is flagged illegal.
- One output register stage with valid/ready handshakes on both sides; stalls on a read-after-write against the instruction it holds.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- SRA_BIT, 10, position of the arithmetic-shift select bit in B, matching the ALU's convention.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rs1_addr  out  5  regfile read address 1; combinational from in_instr[19:15]
- rs2_addr  out  5  regfile read address 2; combinational from in_instr[24:20]
- rs1_data  in  32  regfile read data 1; combinational/asynchronous read
- rs2_data  in  32  regfile read data 2
- wb_valid  in  1  writeback this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- out_valid  out  1  operands valid
- out_ready  in  1  ALU stage consumes
- out_a  out  32  ALU A
- out_b  out  32  ALU B
- out_ctrl  out  3  ALU ctrl (funct3 encoding: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl/sra, 6 or, 7 and)
- out_rd  out  5  destination register
- out_wb_en  out  1  result is written back
- out_illegal  out  1  unsupported or illegal encoding

Behaviour:
- Reset: out_valid=0; out_a, out_b, out_ctrl, out_rd, out_wb_en, out_illegal all 0. Reset mid-stall discards the held instruction.
- Accept condition: accept = in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !hazard.
  - On accept, all out_* load next edge and out_valid=1.
  - If out_ready && out_valid && !accept, out_valid clears next edge.
  - When neither occurs, all out_* hold.
- Latency: 1 cycle from accept to out_valid.
- Hazard:
  - hazard = in_valid && out_valid && out_wb_en && out_rd!=0 && ((uses_rs1 && rs1_addr==out_rd) || (uses_rs2 && rs2_addr==out_rd)).
  - While hazard is high the output still drains normally. Downstream delivers that result on wb_* no later than the cycle the stall releases.
- Forwarding: operand = (wb_valid && wb_rd!=0 && wb_rd==rsN_addr) ? wb_data : rsN_data. Register x0 always reads 0.
- OP-IMM (0010011):
  - A = rs1.
  - B = sign-extended imm[11:0]; ctrl = funct3.
  - funct3 001/101: B = {21'b0, sra, 5'b0, shamt}.
    - sra = (funct7 == 0100000), and only for funct3 101.
    - Any other funct7 is illegal.
- OP (0110011):
  - A = rs1; B = rs2; ctrl = funct3.
  - funct7 0100000 with funct3 000 (SUB): B = ~rs2 + 1, ctrl = 0.
  - funct3 001/101: B = {21'b0, sra, 5'b0, rs2[4:0]}.
  - Legal funct7: 0000000 for all funct3; 0100000 only with funct3 000 or 101. Anything else is illegal.
- LUI: A=0, B={imm[31:12],12'b0}, ctrl=0.
- AUIPC: A=in_pc, B={imm[31:12],12'b0}, ctrl=0.
- uses_rs1: OP, OP-IMM. uses_rs2: OP only.
- Illegal: out_illegal=1, out_wb_en=0, out_a=out_b=0, out_ctrl=0. The instruction still passes through the handshake and never causes a hazard.
- Write-back enable: out_wb_en = legal && rd!=0.

Decomposition:
- Package turtle_pkg holds:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC);
  - ALU ctrl constants (ALU_ADD … ALU_AND);
  - funct7 constants (F7_BASE, F7_ALT);
  - SRA_BIT.
- One combinational sub-module, imm_gen: instruction → I/U immediates and shift-B formatting.

Test Plan:
- Reset, then in_valid=1, in_instr=0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, out_a=0, out_b=5, out_ctrl=0, out_rd=1, out_wb_en=1.
- 0x402081B3 (sub x3,x1,x2) with rs1=10, rs2=3 -> out_a=10, out_b=0xFFFFFFFD, out_ctrl=0.
- 0x407352B3 (sra x5,x6,x7) with rs2=0xFFFFFFE4 -> out_b=0x00000404, out_ctrl=5. Repeat with funct7=0 -> out_b=0x00000004.
- 0x12345237 (lui x4) -> out_a=0, out_b=0x12345000. 0x00001317 (auipc x6) at pc=0x100 -> out_a=0x100, out_b=0x1000.
- Hold out_ready=0 with addi x1 in the output register, then present add x2,x1,x1 -> in_ready=0. Raise out_ready -> drain. Next cycle drive wb_rd=1, wb_data=7 -> accepted with out_a=out_b=7.
- 0x00000073 (ecall) -> out_illegal=1, out_wb_en=0, no stall. Assert reset while out_valid=1 -> out_valid=0 next edge.
